// File: rtl/output_fader.sv
// Click-free output fader: ramps a gain between silence and unity in
// RAMP_STEP increments, one step per sample_clk rising edge.
module output_fader #(
   parameter int DATA_BITS = 12,
   parameter int GAIN_BITS = 8,
   parameter int RAMP_STEP = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sample_clk,
   input  logic signed [DATA_BITS-1:0] din,
   input  logic                        mute,
   output logic signed [DATA_BITS-1:0] dout,
   output logic                        dout_valid,
   output logic                        muted,
   output logic                        busy
);

   localparam int GW = GAIN_BITS + 1;
   localparam int PW = DATA_BITS + GAIN_BITS + 1;
   localparam logic [GW-1:0] UNITY = GW'(1) << GAIN_BITS;
   localparam logic [GW-1:0] STEP = GW'(RAMP_STEP);
   localparam logic [GW-1:0] HEADROOM = UNITY - STEP;

   typedef enum logic [1:0] {
      MUTED,
      FADE_IN,
      PLAYING,
      FADE_OUT
   } state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          gain_q, gain_d;
   logic [DATA_BITS-1:0]   dout_q, dout_d;
   logic                   valid_q, valid_d;
   logic                   s_prev_q, s_prev_d;

   logic                   strobe;
   logic [GW-1:0]          gain_up, gain_dn;
   logic signed [PW-1:0]   din_x, gain_x, prod;
   logic                   unused_prod;

   always_comb begin
      strobe   = sample_clk & ~s_prev_q;
      s_prev_d = sample_clk;
      valid_d  = strobe;

      din_x  = $signed({{(PW-DATA_BITS){din[DATA_BITS-1]}}, din});
      gain_x = $signed({{(PW-GW){1'b0}}, gain_q});
      prod   = din_x * gain_x;

      // saturating steps keep gain inside 0..UNITY without a wider adder
      gain_up = (gain_q >= HEADROOM) ? UNITY : gain_q + STEP;
      gain_dn = (gain_q <= STEP) ? '0 : gain_q - STEP;

      state_d = state_q;
      gain_d  = gain_q;
      dout_d  = dout_q;

      if (strobe) begin
         // taking the bits above GAIN_BITS is the floor of prod / UNITY
         dout_d = prod[GAIN_BITS +: DATA_BITS];
         if (mute) begin
            gain_d  = gain_dn;
            state_d = (gain_dn == '0) ? MUTED : FADE_OUT;
         end else begin
            gain_d  = gain_up;
            state_d = (gain_up == UNITY) ? PLAYING : FADE_IN;
         end
      end
   end

   assign unused_prod = ^{prod[GAIN_BITS-1:0], prod[PW-1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= MUTED;
         gain_q   <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         s_prev_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         gain_q   <= gain_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         s_prev_q <= s_prev_d;
      end
   end

   assign dout       = $signed(dout_q);
   assign dout_valid = valid_q;
   assign muted      = (state_q == MUTED);
   assign busy       = (state_q == FADE_IN) || (state_q == FADE_OUT);

endmodule

// File: tb/tb_output_fader.sv
// Bench for output_fader: gain-level reference model checked every clock
// plus literal expectations for the documented fade sequences.
module tb_output_fader;

   localparam int DB    = 12;
   localparam int GB    = 8;
   localparam int STEP  = 64;
   localparam int UNITY = 256;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 sample_clk = 1'b0;
   logic signed [DB-1:0] din = '0;
   logic                 mute = 1'b1;
   logic signed [DB-1:0] dout;
   logic                 dout_valid;
   logic                 muted;
   logic                 busy;

   int tests = 0;
   int fails = 0;

   output_fader #(
      .DATA_BITS(DB),
      .GAIN_BITS(GB),
      .RAMP_STEP(STEP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sample_clk(sample_clk),
      .din       (din),
      .mute      (mute),
      .dout      (dout),
      .dout_valid(dout_valid),
      .muted     (muted),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int floor_div(input int p, input int d);
      int q;
      q = p / d;
      if ((p % d != 0) && (p < 0)) q = q - 1;
      return q;
   endfunction

   // reference model: gain level alone determines muted/busy
   int m_gain = 0;
   int m_dout = 0;
   bit m_valid = 0;
   bit m_prev = 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_gain  = 0;
         m_dout  = 0;
         m_valid = 0;
         m_prev  = 1;
      end else begin
         m_valid = sample_clk && !m_prev;
         m_prev  = sample_clk;
         if (m_valid) begin
            m_dout = floor_div(int'(din) * m_gain, UNITY);
            if (mute) m_gain = (m_gain > STEP) ? m_gain - STEP : 0;
            else      m_gain = (m_gain + STEP > UNITY) ? UNITY : m_gain + STEP;
         end
      end
   end

   always @(negedge clk) begin
      chk("model_dout", int'(dout), m_dout);
      chk("model_valid", int'(dout_valid), int'(m_valid));
      chk("model_muted", int'(muted), int'(m_gain == 0));
      chk("model_busy", int'(busy), int'(m_gain > 0 && m_gain < UNITY));
   end

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      sample_clk = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic strobe(input string nm, input int exp);
      @(posedge clk);
      #2 sample_clk = 1'b1;
      @(posedge clk);
      #2 sample_clk = 1'b0;
      chk(nm, int'(dout), exp);
      chk({nm, "_valid"}, int'(dout_valid), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      do_reset();
      #1;
      chk("rst_dout", int'(dout), 0);
      chk("rst_muted", int'(muted), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(dout_valid), 0);

      // fade in from silence
      mute = 1'b0;
      din  = 12'sd1000;
      strobe("fi1", 0);
      chk("fi1_busy", int'(busy), 1);
      chk("fi1_muted", int'(muted), 0);
      strobe("fi2", 250);
      strobe("fi3", 500);
      chk("fi3_busy", int'(busy), 1);
      strobe("fi4", 750);
      chk("fi4_busy", int'(busy), 0);
      strobe("fi5", 1000);
      strobe("fi6", 1000);
      chk("fi6_muted", int'(muted), 0);

      // negative values round toward -inf
      do_reset();
      mute = 1'b0;
      din  = 12'sd0;
      strobe("neg0", 0);
      din = -12'sd1000;
      strobe("neg1000", -250);
      mute = 1'b1;
      din  = 12'sd0;
      strobe("neg_dn", 0);
      mute = 1'b0;
      din  = -12'sd3;
      strobe("neg3", -1);
      mute = 1'b1;
      din  = 12'sd0;
      strobe("neg_dn2", 0);
      din = 12'sd3;
      strobe("pos3", 0);
      chk("pos3_muted", int'(muted), 1);

      // reversal mid fade-in
      do_reset();
      mute = 1'b0;
      din  = 12'sd1000;
      strobe("rv1", 0);
      strobe("rv2", 250);
      mute = 1'b1;
      strobe("rv3", 500);
      strobe("rv4", 250);
      strobe("rv5", 0);
      chk("rv5_muted", int'(muted), 1);

      // full scale passes unchanged at unity
      mute = 1'b0;
      din  = 12'sd0;
      repeat (4) strobe("ramp", 0);
      din = -12'sd2048;
      strobe("fs_neg", -2048);
      din = 12'sd2047;
      strobe("fs_pos", 2047);
      @(posedge clk);
      #2 sample_clk = 1'b1;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         n += int'(dout_valid);
      end
      chk("one_pulse", n, 1);
      n = 0;
      repeat (20) begin
         @(negedge clk);
         n += int'(dout_valid);
      end
      chk("static_hi", n, 0);
      #2 sample_clk = 1'b0;

      // mute glitch between strobes is ignored
      do_reset();
      mute = 1'b0;
      din  = 12'sd1000;
      strobe("gl1", 0);
      mute = 1'b1;
      repeat (3) @(posedge clk);
      #2 mute = 1'b0;
      chk("gl_busy", int'(busy), 1);
      strobe("gl2", 250);

      // reset mid-fade with sample_clk high at release
      @(posedge clk);
      #2 sample_clk = 1'b1;
      rst = 1'b1;
      #1;
      chk("ar_dout", int'(dout), 0);
      chk("ar_muted", int'(muted), 1);
      chk("ar_valid", int'(dout_valid), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      n = 0;
      repeat (4) begin
         @(negedge clk);
         n += int'(dout_valid);
      end
      chk("rel_nostrobe", n, 0);
      chk("rel_muted", int'(muted), 1);
      #2 sample_clk = 1'b0;
      strobe("rs1", 0);
      strobe("rs2", 250);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/output_fader.md
OUTPUT_FADER -- requirements
Module: output_fader

Interface
REQ-001 SHALL have parameter DATA_BITS, default 12, sample width (signed two's complement).
REQ-002 SHALL have parameter GAIN_BITS, default 8; unity gain UNITY = 2^GAIN_BITS.
REQ-003 SHALL have parameter RAMP_STEP, default 1, gain increment/decrement per sample (1..UNITY).
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port sample_clk  input  1  sample-rate clock (clock_divider output, clk-synchronous level).
REQ-007 SHALL have port din  input  DATA_BITS  signed mix from song_player.
REQ-008 SHALL have port mute  input  1  1 = fade to silence, 0 = fade to unity.
REQ-009 SHALL have port dout  output  DATA_BITS  signed faded sample to pdm_dac.
REQ-010 SHALL have port dout_valid  output  1  one-clk pulse when dout updates.
REQ-011 SHALL have port muted  output  1  high while state is MUTED.
REQ-012 SHALL have port busy  output  1  high while state is FADE_IN or FADE_OUT.

Function
REQ-013 SHALL register sample_clk into s_prev each clk; strobe = sample_clk & ~s_prev (one clk per sample_clk rising edge).
REQ-014 SHALL keep gain register, GAIN_BITS+1 bits unsigned, range 0..UNITY, never outside.
REQ-015 SHALL implement states MUTED, FADE_IN, PLAYING, FADE_OUT; state, gain, dout change only on strobe cycles (except reset).
REQ-016 On strobe SHALL load dout <= (din * gain) >>> GAIN_BITS using pre-update gain; product signed DATA_BITS+GAIN_BITS+1 bits; shift arithmetic (floor toward -inf); no overflow possible since gain <= UNITY.
REQ-017 SHALL assert dout_valid for exactly the clk cycle after a strobe; 0 otherwise; latency strobe -> dout = 1 clk.
REQ-018 MUTED: mute=1 -> stay, gain 0; mute=0 -> gain <= min(RAMP_STEP,UNITY), state FADE_IN (PLAYING if result = UNITY).
REQ-019 FADE_IN: mute=0 -> gain <= min(gain+RAMP_STEP,UNITY), PLAYING when result = UNITY; mute=1 -> gain <= max(gain-RAMP_STEP,0), FADE_OUT (MUTED if result = 0).
REQ-020 PLAYING: mute=0 -> stay, gain UNITY; mute=1 -> gain <= UNITY-RAMP_STEP clamped at 0, FADE_OUT (MUTED if 0).
REQ-021 FADE_OUT: mute=1 -> gain <= max(gain-RAMP_STEP,0), MUTED when result = 0; mute=0 -> gain <= min(gain+RAMP_STEP,UNITY), FADE_IN (PLAYING if UNITY).
REQ-022 mid-fade direction reversal SHALL continue from current gain, no jump.
REQ-023 mute SHALL be sampled only on strobe cycles; changes between strobes ignored until next strobe.
REQ-024 At UNITY dout SHALL equal din bit-exact (din=-2^(DATA_BITS-1) and 2^(DATA_BITS-1)-1 pass unchanged).
REQ-025 muted = (state==MUTED); busy = (state==FADE_IN || state==FADE_OUT); both combinational from state.

Reset
REQ-026 rst=1 SHALL asynchronously force state MUTED, gain 0, dout 0, dout_valid 0, s_prev 1.
REQ-027 s_prev reset to 1 SHALL suppress a strobe if sample_clk is high at reset release; first strobe requires a low-then-high sample_clk.
REQ-028 Reset asserted mid-fade SHALL abort the fade; after release fade-in restarts from gain 0.

Verification (DATA_BITS=12, GAIN_BITS=8, RAMP_STEP=64)
REQ-029 Reset, mute=0, din=1000, 6 strobes -> dout 0,250,500,750,1000,1000; busy high after strobes 1-3, low from strobe 4; muted low from strobe 1.
REQ-030 Negative floor: gain 64, din=-1000 -> dout -250; din=-3 -> dout -1; din=3 -> dout 0.
REQ-031 Reversal: FADE_IN at gain 128, mute=1 at strobe -> dout uses 128 (din=1000 -> 500), then 250, then 0, muted=1 after third strobe.
REQ-032 PLAYING, din=-2048 then 2047 -> dout -2048, 2047 exact; dout_valid exactly one clk per strobe, none when sample_clk static.
REQ-033 mute toggled 1->0 between strobes -> no state/gain change until next strobe; rst pulse mid-fade -> dout 0, muted 1 immediately, sample_clk high at release gives no strobe.
